// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-front-end PC sequencer.
// Encodings of state_t are visible on the sequencer's state port.
package pc_seq_pkg;

    localparam int PC_W = 16;

    localparam logic [PC_W-1:0] DEFAULT_RESET_VEC = 16'h0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        BUBBLE = 2'd2,
        HALT   = 2'd3
    } state_t;

endpackage

// File: rtl/Inc16.sv
// 16-bit incrementer shared across the pipeline; carry flags the FFFF -> 0000 rollover.
module Inc16 (
    input  logic [15:0] a,
    output logic [15:0] y,
    output logic        carry
);

    assign {carry, y} = {1'b0, a} + 17'd1;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: offers the PC to fetch over valid/ready, advances it on
// each accepted fetch, and handles start/halt control plus redirects with a one-cycle bubble.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_VEC  = DEFAULT_RESET_VEC,
    parameter bit              AUTO_START = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            halt_req,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_addr,
    output logic            fetch_valid,
    output logic [PC_W-1:0] fetch_addr,
    input  logic            fetch_ready,
    output logic            wrap,
    output logic [1:0]      state
);

    localparam state_t RESET_STATE = AUTO_START ? RUN : IDLE;

    state_t          cur_state;
    state_t          next_state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_next;
    logic [PC_W-1:0] pc_inc;
    logic            inc_carry;
    logic            wrap_next;
    logic            hs;

    Inc16 u_inc (
        .a     (pc),
        .y     (pc_inc),
        .carry (inc_carry)
    );

    assign hs = fetch_valid & fetch_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= RESET_STATE;
        end else begin
            cur_state <= next_state;
        end
    end

    always_comb begin
        next_state = cur_state;
        unique case (cur_state)
            IDLE: begin
                if (start) next_state = RUN;
            end
            RUN: begin
                if (redirect_valid) next_state = halt_req ? HALT : BUBBLE;
                else if (halt_req)  next_state = HALT;
            end
            BUBBLE: begin
                // A redirect landing in the bubble buys one more empty cycle unless halting.
                if (halt_req)            next_state = HALT;
                else if (!redirect_valid) next_state = RUN;
            end
            HALT: begin
                if (start && !halt_req) next_state = RUN;
            end
            default: next_state = RESET_STATE;
        endcase
    end

    always_comb begin
        fetch_valid = (cur_state == RUN);
        fetch_addr  = pc;
        state       = cur_state;
    end

    // A redirect always beats the increment, even when the same cycle also handshakes.
    always_comb begin
        pc_next   = pc;
        wrap_next = 1'b0;
        unique case (cur_state)
            RUN: begin
                if (redirect_valid) begin
                    pc_next = redirect_addr;
                end else if (hs) begin
                    pc_next   = pc_inc;
                    wrap_next = inc_carry;
                end
            end
            BUBBLE, HALT: begin
                if (redirect_valid) pc_next = redirect_addr;
            end
            default: pc_next = pc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc   <= RESET_VEC;
            wrap <= 1'b0;
        end else begin
            pc   <= pc_next;
            wrap <= wrap_next;
        end
    end

endmodule
